ucsbece154b_victim_swap_ctrl: RTL and testbench

L1-side miss controller that owns the other end of the victim cache interface. On each L1 miss it looks the line up in the victim cache, writes the L1's evicted line into the victim cache, and returns the requested line to the L1. The line comes from the victim cache on a hit (swap) or from a beat-serial memory refill on a miss. It sits between the L1 tag/data arrays, the victim cache and the memory port.

---
 rtl/ucsbece154b_victim_pkg.sv | 25 ++
 rtl/ucsbece154b_line_assembler.sv | 52 +++++
 rtl/ucsbece154b_victim_swap_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ucsbece154b_victim_swap_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_victim_pkg.sv
// Shared types and size helpers for the L1-side victim swap controller.
package ucsbece154b_victim_pkg;

    localparam int unsigned LineWidth = 128;

    typedef logic [LineWidth-1:0] line_t;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMemReq,
        StMemWait,
        StFill
    } swap_state_e;

    function automatic int unsigned calc_beats(input int unsigned line_w,
                                               input int unsigned mem_w);
        return line_w / mem_w;
    endfunction

    function automatic int unsigned calc_offset_width(input int unsigned line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/ucsbece154b_line_assembler.sv
// Collects MEM_WIDTH beats into one cache line; beat k lands at bits [k*MEM_WIDTH +: MEM_WIDTH].
module ucsbece154b_line_assembler
    import ucsbece154b_victim_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned MEM_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  beat_valid_i,
    input  logic [MEM_WIDTH-1:0]  beat_i,
    output logic [LINE_WIDTH-1:0] line_o,
    output logic                  last_o
);

    localparam int unsigned Beats = calc_beats(LINE_WIDTH, MEM_WIDTH);
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;

    assign last_o = beat_valid_i && (cnt_q == LastCnt);
    assign line_o = line_q;

    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (beat_valid_i) begin
            for (int unsigned k = 0; k < Beats; k++) begin
                if (cnt_q == CntW'(k)) begin
                    line_d[k*MEM_WIDTH +: MEM_WIDTH] = beat_i;
                end
            end
            cnt_d = last_o ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/ucsbece154b_victim_swap_ctrl.sv
// L1 miss controller: victim cache lookup/swap, else beat-serial memory refill.
// Optional VICTIM_SWAP_STATS_EN adds saturating hit/miss counters.
module ucsbece154b_victim_swap_ctrl
    import ucsbece154b_victim_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 56,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned MEM_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    input  logic                  evict_valid_i,
    input  logic [ADDR_WIDTH-1:0] evict_addr_i,
    input  logic [LINE_WIDTH-1:0] evict_data_i,
    output logic                  fill_valid_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [LINE_WIDTH-1:0] fill_data_o,
    output logic                  fill_from_vc_o,
    output logic                  vc_en_o,
    output logic                  vc_flush_o,
    output logic [ADDR_WIDTH-1:0] vc_raddr_o,
    input  logic                  vc_hit_i,
    input  logic [LINE_WIDTH-1:0] vc_rdata_i,
    output logic                  vc_we_o,
    output logic [ADDR_WIDTH-1:0] vc_waddr_o,
    output logic [LINE_WIDTH-1:0] vc_wdata_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [MEM_WIDTH-1:0]  mem_rsp_data_i
`ifdef VICTIM_SWAP_STATS_EN
    ,
    output logic [31:0]           vc_hit_count_o,
    output logic [31:0]           vc_miss_count_o
`endif
);

    localparam int unsigned OffW = calc_offset_width(LINE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] OffMask =
        ~((ADDR_WIDTH'(1) << OffW) - ADDR_WIDTH'(1));

    swap_state_e           state_q;
    logic [ADDR_WIDTH-1:0] miss_addr_q, evict_addr_q, mem_req_addr_q;
    logic [LINE_WIDTH-1:0] evict_data_q, vc_line_q, asm_line;
    logic                  evict_valid_q, fill_valid_q, fill_from_vc_q;
    logic                  mem_req_valid_q, drop_q, vc_en_q, asm_last;

    ucsbece154b_line_assembler #(
        .LINE_WIDTH(LINE_WIDTH),
        .MEM_WIDTH (MEM_WIDTH)
    ) u_line_assembler (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (state_q == StIdle && miss_valid_i),
        .beat_valid_i(state_q == StMemWait && mem_rsp_valid_i),
        .beat_i      (mem_rsp_data_i),
        .line_o      (asm_line),
        .last_o      (asm_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            miss_addr_q     <= '0;
            evict_valid_q   <= 1'b0;
            evict_addr_q    <= '0;
            evict_data_q    <= '0;
            vc_line_q       <= '0;
            fill_valid_q    <= 1'b0;
            fill_from_vc_q  <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            drop_q          <= 1'b0;
            vc_en_q         <= 1'b0;
        end else begin
            vc_en_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (miss_valid_i) begin
                        miss_addr_q   <= miss_addr_i;
                        evict_valid_q <= evict_valid_i;
                        evict_addr_q  <= evict_addr_i;
                        evict_data_q  <= evict_data_i;
                        drop_q        <= 1'b0;
                        state_q       <= StLookup;
                    end
                end
                StLookup: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else if (vc_hit_i) begin
                        vc_line_q      <= vc_rdata_i;
                        fill_from_vc_q <= 1'b1;
                        fill_valid_q   <= 1'b1;
                        state_q        <= StFill;
                    end else begin
                        fill_from_vc_q  <= 1'b0;
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= miss_addr_q & OffMask;
                        state_q         <= StMemReq;
                    end
                end
                StMemReq: begin
                    // Once accepted, the beats must still be drained even if flushed.
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        drop_q          <= flush_i;
                        state_q         <= StMemWait;
                    end else if (flush_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= StIdle;
                    end
                end
                StMemWait: begin
                    if (flush_i) drop_q <= 1'b1;
                    if (asm_last) begin
                        if (drop_q || flush_i) begin
                            state_q <= StIdle;
                        end else begin
                            fill_valid_q <= 1'b1;
                            state_q      <= StFill;
                        end
                    end
                end
                StFill: begin
                    fill_valid_q <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign miss_ready_o    = (state_q == StIdle) && !rst_i;
    assign fill_valid_o    = fill_valid_q && !flush_i;
    assign fill_addr_o     = miss_addr_q;
    assign fill_data_o     = fill_from_vc_q ? vc_line_q : asm_line;
    assign fill_from_vc_o  = fill_from_vc_q;
    assign vc_en_o         = vc_en_q;
    assign vc_flush_o      = flush_i;
    assign vc_raddr_o      = (state_q == StLookup) ? miss_addr_q : '0;
    assign vc_we_o         = (state_q == StLookup) && evict_valid_q && !flush_i;
    assign vc_waddr_o      = evict_addr_q;
    assign vc_wdata_o      = evict_data_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_addr_o  = mem_req_addr_q;

`ifdef VICTIM_SWAP_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StLookup && !flush_i) begin
            if (vc_hit_i && hit_cnt_q != '1)        hit_cnt_q  <= hit_cnt_q + 32'd1;
            else if (!vc_hit_i && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign vc_hit_count_o  = hit_cnt_q;
    assign vc_miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_victim_swap_ctrl.sv
// Directed bench for the victim swap controller: VC hit, memory refill, stall, flushes, reset.
module tb_ucsbece154b_victim_swap_ctrl;
    import ucsbece154b_victim_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, miss_valid_i, evict_valid_i, vc_hit_i;
    logic        mem_req_ready_i, mem_rsp_valid_i;
    logic [55:0] miss_addr_i, evict_addr_i;
    line_t       evict_data_i, vc_rdata_i;
    logic [31:0] mem_rsp_data_i;
    logic        miss_ready_o, fill_valid_o, fill_from_vc_o, vc_en_o, vc_flush_o;
    logic        vc_we_o, mem_req_valid_o;
    logic [55:0] fill_addr_o, vc_raddr_o, vc_waddr_o, mem_req_addr_o;
    line_t       fill_data_o, vc_wdata_o;
`ifdef VICTIM_SWAP_STATS_EN
    logic [31:0] vc_hit_count_o, vc_miss_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int fill_cnt = 0;
    int we_cnt   = 0;

    always #5 clk = ~clk;

    ucsbece154b_victim_swap_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .miss_valid_i   (miss_valid_i),
        .miss_ready_o   (miss_ready_o),
        .miss_addr_i    (miss_addr_i),
        .evict_valid_i  (evict_valid_i),
        .evict_addr_i   (evict_addr_i),
        .evict_data_i   (evict_data_i),
        .fill_valid_o   (fill_valid_o),
        .fill_addr_o    (fill_addr_o),
        .fill_data_o    (fill_data_o),
        .fill_from_vc_o (fill_from_vc_o),
        .vc_en_o        (vc_en_o),
        .vc_flush_o     (vc_flush_o),
        .vc_raddr_o     (vc_raddr_o),
        .vc_hit_i       (vc_hit_i),
        .vc_rdata_i     (vc_rdata_i),
        .vc_we_o        (vc_we_o),
        .vc_waddr_o     (vc_waddr_o),
        .vc_wdata_o     (vc_wdata_o),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o (mem_req_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i (mem_rsp_data_i)
`ifdef VICTIM_SWAP_STATS_EN
        ,
        .vc_hit_count_o (vc_hit_count_o),
        .vc_miss_count_o(vc_miss_count_o)
`endif
    );

    // Pulse counters; only read at negedges where the pulse is low.
    always @(negedge clk) begin
        if (fill_valid_o) fill_cnt++;
        if (vc_we_o)      we_cnt++;
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to the drive point of the next cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a miss in an IDLE cycle; returns at the drive point of the LOOKUP cycle.
    task automatic start_miss(input logic [55:0] addr, input logic ev, input logic [55:0] ev_addr,
                              input line_t ev_data);
        miss_valid_i  = 1'b1;
        miss_addr_i   = addr;
        evict_valid_i = ev;
        evict_addr_i  = ev_addr;
        evict_data_i  = ev_data;
        @(negedge clk);
        check_eq("miss_ready_idle", miss_ready_o, 1'b1);
        cyc();
        miss_valid_i  = 1'b0;
        evict_valid_i = 1'b0;
    endtask

    // Handshake in MEM_REQ; returns at the drive point of the first MEM_WAIT cycle.
    task automatic mem_accept(input logic [55:0] exp_addr);
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        check_eq("req_valid", mem_req_valid_o, 1'b1);
        check_eq("req_addr", mem_req_addr_o, exp_addr);
        cyc();
        mem_req_ready_i = 1'b0;
    endtask

    task automatic do_beats(input line_t line, input int flush_at);
        for (int k = 0; k < 4; k++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = line[k*32 +: 32];
            flush_i         = (k == flush_at);
            if (k == flush_at) begin
                @(negedge clk);
                check_eq("vc_flush_fwd", vc_flush_o, 1'b1);
            end
            cyc();
        end
        mem_rsp_valid_i = 1'b0;
        flush_i         = 1'b0;
    endtask

    task automatic check_fill(input string tag, input logic [55:0] addr, input line_t data,
                              input logic from_vc);
        @(negedge clk);
        check_eq({tag, "_valid"}, fill_valid_o, 1'b1);
        check_eq({tag, "_addr"}, fill_addr_o, addr);
        check_eq({tag, "_data"}, fill_data_o, data);
        check_eq({tag, "_src"}, fill_from_vc_o, from_vc);
        check_eq({tag, "_ready"}, miss_ready_o, 1'b0);
        cyc();
        @(negedge clk);
        check_eq({tag, "_one_shot"}, fill_valid_o, 1'b0);
        check_eq({tag, "_back_idle"}, miss_ready_o, 1'b1);
        cyc();
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; miss_valid_i = 1'b0; evict_valid_i = 1'b0;
        vc_hit_i = 1'b0; mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
        miss_addr_i = '0; evict_addr_i = '0; evict_data_i = '0; vc_rdata_i = '0;
        mem_rsp_data_i = '0;

        // Reset state
        @(negedge clk);
        check_eq("rst_miss_ready", miss_ready_o, 1'b0);
        check_eq("rst_vc_en", vc_en_o, 1'b0);
        check_eq("rst_fill_valid", fill_valid_o, 1'b0);
        check_eq("rst_req_valid", mem_req_valid_o, 1'b0);
        check_eq("rst_we", vc_we_o, 1'b0);
        check_eq("rst_src", fill_from_vc_o, 1'b0);
        check_eq("rst_fill_data", fill_data_o, 128'h0);
        check_eq("rst_req_addr", mem_req_addr_o, 56'h0);
        cyc();
        rst_i = 1'b0;
        cyc();
        @(negedge clk);
        check_eq("vc_en_run", vc_en_o, 1'b1);
        cyc();

        // VC hit at 0x100: swap, evict written once, fill two cycles after handshake
        start_miss(56'h100, 1'b1, 56'h5000, {4{32'hDEADBEEF}});
        vc_hit_i   = 1'b1;
        vc_rdata_i = {8{16'hAAAA}};
        @(negedge clk);
        check_eq("lk_raddr", vc_raddr_o, 56'h100);
        check_eq("lk_we", vc_we_o, 1'b1);
        check_eq("lk_waddr", vc_waddr_o, 56'h5000);
        check_eq("lk_wdata", vc_wdata_o, {4{32'hDEADBEEF}});
        cyc();
        vc_hit_i = 1'b0;
        check_fill("hit", 56'h100, {8{16'hAAAA}}, 1'b1);
        check_eq("hit_we_once", we_cnt, 1);

        // Stray response beat while idle must be ignored
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'hBAD0BAD0;
        cyc();
        mem_rsp_valid_i = 1'b0;

        // VC miss: memory refill, offset bits cleared in the request
        start_miss(56'h208, 1'b1, 56'h6000, {4{32'h12345678}});
        @(negedge clk);
        check_eq("miss_we", vc_we_o, 1'b1);
        cyc();
        mem_accept(56'h200);
        do_beats(128'h44444444_33333333_22222222_11111111, -1);
        check_fill("mem", 56'h208, 128'h44444444_33333333_22222222_11111111, 1'b0);

        // Request stalled five cycles: held valid and stable, no fill
        start_miss(56'h3F4, 1'b1, 56'h7000, '0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_valid", mem_req_valid_o, 1'b1);
            check_eq("stall_addr", mem_req_addr_o, 56'h3F0);
            cyc();
        end
        check_eq("stall_no_fill", fill_cnt, 2);
        mem_accept(56'h3F0);
        do_beats(128'hCAFEF00D_89ABCDEF_01234567_0F0F0F0F, -1);
        check_fill("stall", 56'h3F4, 128'hCAFEF00D_89ABCDEF_01234567_0F0F0F0F, 1'b0);

        // Flush on the second beat: beats drained, no fill, idle after the fourth beat
        start_miss(56'h440, 1'b0, '0, '0);
        cyc();
        mem_accept(56'h440);
        do_beats(128'h55555555_66666666_77777777_88888888, 1);
        @(negedge clk);
        check_eq("flush_no_fill", fill_valid_o, 1'b0);
        check_eq("flush_idle", miss_ready_o, 1'b1);
        check_eq("flush_fill_cnt", fill_cnt, 3);
        cyc();

        // No evict: no victim write on a hit
        start_miss(56'h500, 1'b0, 56'h9999, {4{32'h1}});
        vc_hit_i   = 1'b1;
        vc_rdata_i = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        @(negedge clk);
        check_eq("noev_we", vc_we_o, 1'b0);
        cyc();
        vc_hit_i = 1'b0;
        check_fill("noev", 56'h500, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1);
        check_eq("noev_we_cnt", we_cnt, 3);

        // Flush in LOOKUP: write suppressed, back to idle
        start_miss(56'h600, 1'b1, 56'h8000, '1);
        flush_i  = 1'b1;
        vc_hit_i = 1'b1;
        @(negedge clk);
        check_eq("lkfl_we", vc_we_o, 1'b0);
        check_eq("lkfl_fwd", vc_flush_o, 1'b1);
        cyc();
        flush_i  = 1'b0;
        vc_hit_i = 1'b0;
        @(negedge clk);
        check_eq("lkfl_idle", miss_ready_o, 1'b1);
        check_eq("lkfl_no_fill", fill_valid_o, 1'b0);
        check_eq("lkfl_we_cnt", we_cnt, 3);
        cyc();

        // Flush in MEM_REQ before handshake drops the request
        start_miss(56'h700, 1'b0, '0, '0);
        cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        @(negedge clk);
        check_eq("rqfl_valid", mem_req_valid_o, 1'b0);
        check_eq("rqfl_idle", miss_ready_o, 1'b1);
        cyc();

        // Third hit
        start_miss(56'h800, 1'b1, 56'hA000, {4{32'h0BADCAFE}});
        vc_hit_i   = 1'b1;
        vc_rdata_i = {4{32'h13572468}};
        cyc();
        vc_hit_i = 1'b0;
        check_fill("hit3", 56'h800, {4{32'h13572468}}, 1'b1);
        check_eq("hit3_we_cnt", we_cnt, 4);
`ifdef VICTIM_SWAP_STATS_EN
        check_eq("stat_hits", vc_hit_count_o, 32'd3);
        check_eq("stat_misses", vc_miss_count_o, 32'd4);
`endif

        // Reset mid-MEM_WAIT: immediate idle, rest of response ignored
        start_miss(56'h900, 1'b0, '0, '0);
        cyc();
        mem_accept(56'h900);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'hFFFF0000;
        cyc();
        rst_i = 1'b1;
        @(negedge clk);
        check_eq("mrst_ready", miss_ready_o, 1'b0);
        check_eq("mrst_vc_en", vc_en_o, 1'b0);
`ifdef VICTIM_SWAP_STATS_EN
        check_eq("mrst_hits", vc_hit_count_o, 32'd0);
        check_eq("mrst_misses", vc_miss_count_o, 32'd0);
`endif
        cyc();
        rst_i = 1'b0;
        cyc();
        cyc();
        mem_rsp_valid_i = 1'b0;
        @(negedge clk);
        check_eq("mrst_idle", miss_ready_o, 1'b1);
        check_eq("mrst_no_fill", fill_cnt, 5);
        cyc();

        // Fresh refill after reset starts at beat 0
        start_miss(56'hA0C, 1'b0, '0, '0);
        cyc();
        mem_accept(56'hA00);
        do_beats(128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4, -1);
        check_fill("post_rst", 56'hA0C, 128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
